// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared types and helpers for the sequential Booth multiplier.
//   state_t    : controller states (IDLE, RUN, DONE)
//   cnt_width(): bit width of the step counter for a given operand WIDTH;
//                it must hold WIDTH+1, the number of Booth steps.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration on E-bit registers.
//   a, m, q, qm1         : accumulator, multiplicand, multiplier, q(-1) bit
//   a_nx, q_nx, qm1_nx   : values after add/sub selection and the arithmetic
//                          right shift of {A,Q,q-1}
module booth_step #(
  parameter int unsigned E = 17
) (
  input  logic [E-1:0] a,
  input  logic [E-1:0] m,
  input  logic [E-1:0] q,
  input  logic         qm1,
  output logic [E-1:0] a_nx,
  output logic [E-1:0] q_nx,
  output logic         qm1_nx
);

  logic [E-1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], qm1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // Operands carry one extension bit, so sum cannot overflow and its MSB
    // is the true sign to replicate.
    {a_nx, q_nx, qm1_nx} = {sum[E-1], sum, q};
  end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-2 Booth multiplier, one step per clock.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid/in_ready, a, b, is_signed : operand handshake (WIDTH bits each)
//   out_valid/out_ready, p             : product handshake (2*WIDTH bits)
//   ovf         : product does not fit in WIDTH bits of the selected mode;
//                 present only when BOOTH_MUL_OVF_EN is defined
// Latency WIDTH+1 clocks from accept to out_valid.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
`ifdef BOOTH_MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned E  = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t        state;
  state_t        state_nx;

  logic [E-1:0]  acc;
  logic [E-1:0]  mcand;
  logic [E-1:0]  mplier;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [E-1:0]  acc_nx;
  logic [E-1:0]  mplier_nx;
  logic          qm1_nx;

  logic [E-1:0]  a_ext;
  logic [E-1:0]  b_ext;
  logic          last_step;
  logic [PW-1:0] prod_nx;

  booth_step #(.E(E)) u_step (
    .a      (acc),
    .m      (mcand),
    .q      (mplier),
    .qm1    (qm1),
    .a_nx   (acc_nx),
    .q_nx   (mplier_nx),
    .qm1_nx (qm1_nx)
  );

  always_comb begin
    a_ext     = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext     = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
    last_step = (state == RUN) && (cnt == CW'(1));
    // Low 2*WIDTH bits of {A,Q}; the top two bits of A only repeat the sign.
    prod_nx   = {acc_nx[E-3:0], mplier_nx};
  end

`ifdef BOOTH_MUL_OVF_EN
  logic sgn_mode;
  logic ovf_nx;

  always_comb begin
    if (sgn_mode) begin
      ovf_nx = !((&prod_nx[PW-1:WIDTH-1]) || (~|prod_nx[PW-1:WIDTH-1]));
    end else begin
      ovf_nx = |prod_nx[PW-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_mode <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sgn_mode <= is_signed;
      end
      if (last_step) begin
        ovf <= ovf_nx;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= a_ext;
            mplier <= b_ext;
            qm1    <= 1'b0;
            cnt    <= CW'(E);
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mplier <= mplier_nx;
          qm1    <= qm1_nx;
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            p <= prod_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq at
// WIDTH=16 (main), 8 and 32. ovf checks are compiled in with BOOTH_MUL_OVF_EN.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  // WIDTH=16
  logic        iv16 = 1'b0, ir16, sg16 = 1'b0, ov16, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  // WIDTH=8
  logic        iv8 = 1'b0, ir8, sg8 = 1'b0, ov8, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  // WIDTH=32
  logic        iv32 = 1'b0, ir32, sg32 = 1'b0, ov32, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] p32;
`ifdef BOOTH_MUL_OVF_EN
  logic f16, f8, f32;
`endif

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(sg16), .out_valid(ov16), .out_ready(or16), .p(p16)
`ifdef BOOTH_MUL_OVF_EN
    , .ovf(f16)
`endif
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(sg8), .out_valid(ov8), .out_ready(or8), .p(p8)
`ifdef BOOTH_MUL_OVF_EN
    , .ovf(f8)
`endif
  );

  booth_mul_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(sg32), .out_valid(ov32), .out_ready(or32), .p(p32)
`ifdef BOOTH_MUL_OVF_EN
    , .ovf(f32)
`endif
  );

  // Drivers for the WIDTH=16 instance (no comparisons inside).
  task automatic start16(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
    a16 = ta; b16 = tb; sg16 = ts; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic wait16(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ov16) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic finish16();
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ir16 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", ir16); end
    checks++;
    if (ov16 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
    checks++;
    if (p16 !== 32'h0) begin failures++; $display("FAIL reset_p: got %h expected 00000000", p16); end
`ifdef BOOTH_MUL_OVF_EN
    checks++;
    if (f16 !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", f16); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_basic();
    int e;
    start16(16'd3, 16'hFFFB, 1'b1);
    wait16(e);
    checks++;
    if (e != 17) begin failures++; $display("FAIL basic_latency: got %0d expected 17", e); end
    checks++;
    if (p16 !== 32'hFFFFFFF1) begin failures++; $display("FAIL basic_p: got %h expected fffffff1", p16); end
    checks++;
    if (ir16 !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done: got %b expected 0", ir16); end
`ifdef BOOTH_MUL_OVF_EN
    checks++;
    if (f16 !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", f16); end
`endif
    finish16();
    checks++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      failures++; $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0/1", ov16, ir16);
    end
  endtask

  task automatic test_corner_operands();
    logic [15:0] va[4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h8000};
    logic [15:0] vb[4] = '{16'h8000, 16'hFFFF, 16'h0002, 16'h0002};
    logic        vs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] vp[4] = '{32'h40000000, 32'hFFFE0001, 32'h00010000, 32'hFFFF0000};
    logic        vo[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    int e;
    for (int i = 0; i < 4; i++) begin
      start16(va[i], vb[i], vs[i]);
      wait16(e);
      checks++;
      if (e != 17 || p16 !== vp[i]) begin
        failures++;
        $display("FAIL corner_p[%0d]: got %h after %0d edges expected %h after 17", i, p16, e, vp[i]);
      end
`ifdef BOOTH_MUL_OVF_EN
      checks++;
      if (f16 !== vo[i]) begin failures++; $display("FAIL corner_ovf[%0d]: got %b expected %b", i, f16, vo[i]); end
`else
      if (vo[i] !== 1'b1) $display("note: unexpected table entry");
`endif
      finish16();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    start16(16'h1234, 16'h0010, 1'b1);
    wait16(e);
    checks++;
    if (e != 17) begin failures++; $display("FAIL bp_latency: got %0d expected 17", e); end
    for (int i = 0; i < 10; i++) begin
      iv16 = i[0];
      a16  = 16'(i + 100);
      b16  = 16'h7FFF;
      @(posedge clk); #1;
      checks++;
      if (ov16 !== 1'b1 || ir16 !== 1'b0 || p16 !== 32'h00012340) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b p=%h expected 1/0/00012340", i, ov16, ir16, p16);
      end
    end
    iv16 = 1'b0;
`ifdef BOOTH_MUL_OVF_EN
    checks++;
    if (f16 !== 1'b1) begin failures++; $display("FAIL bp_ovf: got %b expected 1", f16); end
`endif
    finish16();
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      failures++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", ir16, ov16);
    end
    start16(16'd7, 16'd6, 1'b0);
    wait16(e);
    checks++;
    if (e != 17 || p16 !== 32'd42) begin
      failures++; $display("FAIL b2b_p: got %h after %0d edges expected 0000002a after 17", p16, e);
    end
    finish16();
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic seen;
    start16(16'h00FF, 16'h0101, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || p16 !== 32'h0) begin
      failures++;
      $display("FAIL midrst_state: got in_ready=%b out_valid=%b p=%h expected 1/0/00000000", ir16, ov16, p16);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ov16 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_output: got out_valid pulse expected none"); end
    start16(16'd7, 16'd6, 1'b1);
    wait16(e);
    checks++;
    if (e != 17 || p16 !== 32'd42) begin
      failures++; $display("FAIL midrst_next_p: got %h after %0d edges expected 0000002a after 17", p16, e);
    end
`ifdef BOOTH_MUL_OVF_EN
    checks++;
    if (f16 !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b expected 0", f16); end
`endif
    finish16();
  endtask

  task automatic test_width8();
    logic [7:0]  va[5] = '{8'h80, 8'hFF, 8'hFD, 8'h0C, 8'h7F};
    logic [7:0]  vb[5] = '{8'hFF, 8'hFF, 8'h05, 8'h0A, 8'h02};
    logic        vs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] vp[5] = '{16'h0080, 16'hFE01, 16'hFFF1, 16'h0078, 16'h00FE};
    logic        vo[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int e;
    for (int i = 0; i < 5; i++) begin
      a8 = va[i]; b8 = vb[i]; sg8 = vs[i]; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      e = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (ov8) begin e = k; break; end
      end
      checks++;
      if (e != 9 || p8 !== vp[i]) begin
        failures++; $display("FAIL w8_p[%0d]: got %h after %0d edges expected %h after 9", i, p8, e, vp[i]);
      end
`ifdef BOOTH_MUL_OVF_EN
      checks++;
      if (f8 !== vo[i]) begin failures++; $display("FAIL w8_ovf[%0d]: got %b expected %b", i, f8, vo[i]); end
`else
      if (vo[i] === 1'bx) $display("note: unexpected table entry");
`endif
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
    end
  endtask

  task automatic test_width32();
    logic [31:0] va[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic        vs[3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] vp[3] = '{64'h0000000000000001, 64'hFFFFFFFE00000001, 64'hC000000080000000};
    logic        vo[3] = '{1'b0, 1'b1, 1'b1};
    int e;
    for (int i = 0; i < 3; i++) begin
      a32 = va[i]; b32 = vb[i]; sg32 = vs[i]; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0;
      e = -1;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk); #1;
        if (ov32) begin e = k; break; end
      end
      checks++;
      if (e != 33 || p32 !== vp[i]) begin
        failures++; $display("FAIL w32_p[%0d]: got %h after %0d edges expected %h after 33", i, p32, e, vp[i]);
      end
`ifdef BOOTH_MUL_OVF_EN
      checks++;
      if (f32 !== vo[i]) begin failures++; $display("FAIL w32_ovf[%0d]: got %b expected %b", i, f32, vo[i]); end
`else
      if (vo[i] === 1'bx) $display("note: unexpected table entry");
`endif
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_corner_operands();
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    test_width32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
